// File: rtl/uart_tx_frame.sv
// UART transmit frame generator: start, LSB-first data, optional parity, stop bit(s).
// One clk cycle is one bit period; TX_OUT and busy come straight from flops.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Even parity is the XOR of the payload; odd parity is its complement.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_e                 state_r, state_nxt_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
    logic [DATA_WIDTH-1:0]  shift_r, shift_nxt_s;
    logic                   par_en_r, par_en_nxt_s;
    logic                   par_bit_r, par_bit_nxt_s;
    logic                   tx_out_r, tx_nxt_s;
    logic                   busy_r, busy_nxt_s;

    // State register; the line bit for a state is registered as that state is left,
    // so the serial output trails the FSM by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            shift_r   <= '0;
            par_en_r  <= 1'b0;
            par_bit_r <= 1'b0;
            tx_out_r  <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            shift_r   <= shift_nxt_s;
            par_en_r  <= par_en_nxt_s;
            par_bit_r <= par_bit_nxt_s;
            tx_out_r  <= tx_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        shift_nxt_s   = shift_r;
        par_en_nxt_s  = par_en_r;
        par_bit_nxt_s = par_bit_r;
        tx_nxt_s      = 1'b1;
        busy_nxt_s    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                if (DATA_VALID) begin
                    state_nxt_s   = ST_START;
                    shift_nxt_s   = P_DATA;
                    par_en_nxt_s  = PAR_EN;
                    par_bit_nxt_s = calc_parity(P_DATA, PAR_TYP);
                    cnt_nxt_s     = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                tx_nxt_s    = 1'b0;
                state_nxt_s = ST_DATA;
                cnt_nxt_s   = CNT_ZERO;
            end
            ST_DATA: begin
                tx_nxt_s    = shift_r[0];
                shift_nxt_s = shift_r >> 1;
                if (cnt_r == DATA_LAST) begin
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_PARITY: begin
                tx_nxt_s    = par_bit_r;
                state_nxt_s = ST_STOP;
                cnt_nxt_s   = CNT_ZERO;
            end
            ST_STOP: begin
                tx_nxt_s = 1'b1;
                if (cnt_r == STOP_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    assign TX_OUT = tx_out_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame shapes, parity, busy handling, reset abort
// and a second instance with two stop bits.
module tb_uart_tx_frame;

    logic       clk;
    logic       rst_n;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT, busy;
    logic       tx2, busy2;

    int errors = 0;
    int checks = 0;

    uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
    );

    uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(tx2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one accept edge with a single-cycle DATA_VALID pulse.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
        @(posedge clk); #1;
        DATA_VALID = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; DATA_VALID = 1'b0; P_DATA = 8'h00; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_hold: TX_OUT=%b busy=%b expected 1/0", TX_OUT, busy);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL reset_idle cyc %0d: TX_OUT=%b busy=%b expected 1/0", i, TX_OUT, busy);
            end
        end
    endtask

    // Each entry: data, parity enable, parity type, expected line bits in time order.
    task automatic test_frames;
        logic [7:0] d_tab  [4] = '{8'hA5, 8'hA5, 8'h07, 8'h81};
        logic       pe_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic       pt_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        string      seq_tab[4] = '{"01010010101", "01010010111", "01110000011", "0100000011"};
        for (int f = 0; f < 4; f++) begin
            send(d_tab[f], pe_tab[f], pt_tab[f]);
            for (int i = 0; i < seq_tab[f].len(); i++) begin
                logic exp_bit;
                exp_bit = (seq_tab[f][i] == "1") ? 1'b1 : 1'b0;
                @(posedge clk); #1;
                checks++;
                if (TX_OUT !== exp_bit || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL frame%0d bit %0d: TX_OUT=%b busy=%b expected %b/1", f, i, TX_OUT, busy, exp_bit);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL frame%0d end: TX_OUT=%b busy=%b expected 1/0", f, TX_OUT, busy);
            end
        end
    endtask

    task automatic test_busy_ignore;
        string seq = "0001111001";
        send(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < seq.len(); i++) begin
            logic exp_bit;
            exp_bit = (seq[i] == "1") ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            DATA_VALID = (i == 3) ? 1'b1 : 1'b0;
            P_DATA     = (i == 3) ? 8'hFF : 8'h3C;
            checks++;
            if (TX_OUT !== exp_bit || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_ignore bit %0d: TX_OUT=%b busy=%b expected %b/1", i, TX_OUT, busy, exp_bit);
            end
        end
        DATA_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL busy_ignore idle %0d: TX_OUT=%b busy=%b expected 1/0", i, TX_OUT, busy);
            end
        end
    endtask

    task automatic test_back_to_back;
        string seq1 = "01010101001";
        string seq2 = "00000000011";
        P_DATA = 8'h55; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < seq1.len(); i++) begin
            logic exp_bit;
            exp_bit = (seq1[i] == "1") ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (i == 4) begin
                P_DATA = 8'h00; PAR_TYP = 1'b1;
            end
            checks++;
            if (TX_OUT !== exp_bit || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b frame1 bit %0d: TX_OUT=%b busy=%b expected %b/1", i, TX_OUT, busy, exp_bit);
            end
        end
        @(posedge clk); #1;
        DATA_VALID = 1'b0;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b gap: TX_OUT=%b busy=%b expected 1/0", TX_OUT, busy);
        end
        for (int i = 0; i < seq2.len(); i++) begin
            logic exp_bit;
            exp_bit = (seq2[i] == "1") ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            checks++;
            if (TX_OUT !== exp_bit || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b frame2 bit %0d: TX_OUT=%b busy=%b expected %b/1", i, TX_OUT, busy, exp_bit);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b end: TX_OUT=%b busy=%b expected 1/0", TX_OUT, busy);
        end
    endtask

    task automatic test_reset_mid;
        string seq = "00101101011";
        send(8'h00, 1'b1, 1'b0);
        // Start bit plus data bits 0..3 appear before reset lands.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL abort_pre bit %0d: TX_OUT=%b busy=%b expected 0/1", i, TX_OUT, busy);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_async: TX_OUT=%b busy=%b expected 1/0", TX_OUT, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_idle: TX_OUT=%b busy=%b expected 1/0", TX_OUT, busy);
        end
        send(8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < seq.len(); i++) begin
            logic exp_bit;
            exp_bit = (seq[i] == "1") ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            checks++;
            if (TX_OUT !== exp_bit || busy !== 1'b1) begin
                errors++;
                $display("FAIL after_abort bit %0d: TX_OUT=%b busy=%b expected %b/1", i, TX_OUT, busy, exp_bit);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL after_abort end: TX_OUT=%b busy=%b expected 1/0", TX_OUT, busy);
        end
    endtask

    task automatic test_stop2;
        string seq = "01000000111";
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++; $display("FAIL stop2 pre: TX_OUT=%b busy=%b expected 1/0", tx2, busy2);
        end
        send(8'h81, 1'b0, 1'b0);
        for (int i = 0; i < seq.len(); i++) begin
            logic exp_bit;
            exp_bit = (seq[i] == "1") ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            checks++;
            if (tx2 !== exp_bit || busy2 !== 1'b1) begin
                errors++;
                $display("FAIL stop2 bit %0d: TX_OUT=%b busy=%b expected %b/1", i, tx2, busy2, exp_bit);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++; $display("FAIL stop2 end: TX_OUT=%b busy=%b expected 1/0", tx2, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_stop2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
